// File: rtl/seg_seq_cmd_gen.sv
// Sequential command generator: expands one transfer descriptor into lock-stepped
// addr/dataW/write triplets, closed by an end-of-stream triplet.
module seg_seq_cmd_gen #(
   parameter int AW = 16,
   parameter int DW = 32,
   parameter int LW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cfg_v,
   output logic          cfg_b,
   input  logic [AW-1:0] cfg_base,
   input  logic [LW-1:0] cfg_len,
   input  logic [AW-1:0] cfg_stride,
   input  logic          cfg_write,
   input  logic          src_e,
   input  logic          src_v,
   output logic          src_b,
   input  logic [DW-1:0] src_d,
   output logic          addr_e,
   output logic          addr_v,
   input  logic          addr_b,
   output logic [AW-1:0] addr_d,
   output logic          dataW_e,
   output logic          dataW_v,
   input  logic          dataW_b,
   output logic [DW-1:0] dataW_d,
   output logic          write_e,
   output logic          write_v,
   input  logic          write_b,
   output logic          write_d,
   output logic          busy,
   output logic          err_short
);

   typedef enum logic [1:0] {IDLE, RUN, EOS, DONE} state_t;

   state_t        state;
   logic [AW-1:0] nxt_addr;
   logic [AW-1:0] stride;
   logic [LW-1:0] len;
   logic [LW-1:0] cnt;
   logic          wr_mode;
   logic          src_done;

   logic          out_v;
   logic          out_e;
   logic [AW-1:0] out_a;
   logic [DW-1:0] out_d;
   logic          out_w;

   logic          fire;
   logic          free;
   logic          last;

   assign fire = out_v & ~addr_b & ~dataW_b & ~write_b;
   assign free = ~out_v | fire;
   assign last = (cnt + LW'(1)) == len;

   assign busy  = (state != IDLE);
   assign cfg_b = busy;

   assign addr_v  = out_v;
   assign dataW_v = out_v;
   assign write_v = out_v;
   assign addr_e  = out_e;
   assign dataW_e = out_e;
   assign write_e = out_e;
   assign addr_d  = out_a;
   assign dataW_d = out_d;
   assign write_d = out_w;

   // src is only opened when its token can be used this very cycle
   always_comb begin
      src_b = 1'b1;
      case (state)
         RUN:     if (wr_mode) src_b = ~(free & src_v);
         DONE:    if (wr_mode & ~src_done) src_b = 1'b0;
         default: src_b = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         nxt_addr  <= '0;
         stride    <= '0;
         len       <= '0;
         cnt       <= '0;
         wr_mode   <= 1'b0;
         src_done  <= 1'b0;
         out_v     <= 1'b0;
         out_e     <= 1'b0;
         out_a     <= '0;
         out_d     <= '0;
         out_w     <= 1'b0;
         err_short <= 1'b0;
      end else begin
         if (fire) out_v <= 1'b0;
         case (state)
            IDLE: if (cfg_v) begin
               stride    <= cfg_stride;
               len       <= cfg_len;
               wr_mode   <= cfg_write;
               err_short <= 1'b0;
               src_done  <= 1'b0;
               if (cfg_len == '0) begin
                  cnt   <= '0;
                  state <= EOS;
               end else if (cfg_write) begin
                  nxt_addr <= cfg_base;
                  cnt      <= '0;
                  state    <= RUN;
               end else begin
                  // reads load the first triplet on acceptance to save a cycle
                  out_v    <= 1'b1;
                  out_e    <= 1'b0;
                  out_a    <= cfg_base;
                  out_d    <= '0;
                  out_w    <= 1'b0;
                  nxt_addr <= cfg_base + cfg_stride;
                  cnt      <= LW'(1);
                  state    <= (cfg_len == LW'(1)) ? EOS : RUN;
               end
            end
            RUN: if (free) begin
               if (!wr_mode || (src_v && !src_e)) begin
                  out_v    <= 1'b1;
                  out_e    <= 1'b0;
                  out_a    <= nxt_addr;
                  out_d    <= wr_mode ? src_d : '0;
                  out_w    <= wr_mode;
                  nxt_addr <= nxt_addr + stride;
                  cnt      <= cnt + LW'(1);
                  if (last) state <= EOS;
               end else if (src_v && src_e) begin
                  // upstream ended early: its end token is already consumed
                  err_short <= 1'b1;
                  src_done  <= 1'b1;
                  state     <= EOS;
               end
            end
            EOS: begin
               if (out_v && out_e) begin
                  if (fire) begin
                     out_e <= 1'b0;
                     state <= DONE;
                  end
               end else if (free) begin
                  out_v <= 1'b1;
                  out_e <= 1'b1;
                  out_a <= '0;
                  out_d <= '0;
                  out_w <= 1'b0;
               end
            end
            DONE: begin
               if (!wr_mode || src_done) begin
                  state <= IDLE;
               end else if (src_v) begin
                  if (src_e) state <= IDLE;
                  else       err_short <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
